i2c_regif_fifo: RTL and testbench

//  Processor-facing register interface for the I2C master; next generation of the single-byte register block.

---
 rtl/i2c_regif_pkg.sv | 30 +++
 rtl/i2c_sync_fifo.sv | 71 +++++++
 rtl/i2c_regif_fifo.sv | 137 +++++++++++++
 tb/tb_i2c_regif_fifo.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_regif_pkg.sv
// Shared constants for the I2C master register interface.
// Contents:
//   A_*        register byte addresses on the processor bus
//   ISR_*      bit positions inside the interrupt status/enable registers
//   FLG_*      bit positions of the FIFO flags inside the STATUS register
package i2c_regif_pkg;

    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_COUNT  = 8'h04;
    localparam logic [7:0] A_SADDR  = 8'h08;
    localparam logic [7:0] A_STATUS = 8'h0C;
    localparam logic [7:0] A_TXDATA = 8'h10;
    localparam logic [7:0] A_RXDATA = 8'h14;
    localparam logic [7:0] A_IER    = 8'h18;
    localparam logic [7:0] A_ISR    = 8'h1C;
    localparam logic [7:0] A_LEVEL  = 8'h20;
    localparam logic [7:0] A_FCTRL  = 8'h24;

    localparam int ISR_W        = 4;
    localparam int ISR_TX_OVF   = 0;
    localparam int ISR_RX_UNF   = 1;
    localparam int ISR_RX_AVAIL = 2;
    localparam int ISR_TX_DONE  = 3;

    localparam int FLG_TX_EMPTY = 8;
    localparam int FLG_TX_FULL  = 9;
    localparam int FLG_RX_EMPTY = 10;
    localparam int FLG_RX_FULL  = 11;

endpackage

// File: rtl/i2c_sync_fifo.sv
// Synchronous single-clock FIFO used for the TX and RX byte queues.
// Ports:
//   clk, rstn        clock, synchronous active-high reset
//   push, din        write request and data (ignored when full unless popping)
//   pop              read request (ignored when empty)
//   flush            clears pointers and level; a same-cycle push is discarded
//   dout             head entry
//   empty, full      occupancy flags
//   level            current occupancy
//   level_nxt        occupancy after the coming edge
module i2c_sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = PW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic [LW-1:0] level,
    output logic [LW-1:0] level_nxt
);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign dout    = mem[rd_ptr];
    // A full FIFO still accepts a push when an entry leaves on the same edge.
    assign pop_ok  = pop && !empty && !flush;
    assign push_ok = push && !flush && (!full || pop_ok);

    always_comb begin
        level_nxt = level;
        if (flush) begin
            level_nxt = '0;
        end else begin
            level_nxt = level + LW'(push_ok) - LW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are PW bits wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rstn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            level <= level_nxt;
        end
    end

endmodule

// File: rtl/i2c_regif_fifo.sv
// Processor-facing register block for the I2C master with TX/RX byte FIFOs,
// FIFO level/flag reporting, flush control and a maskable interrupt.
// Ports:
//   CLK, rstn                        clock, synchronous active-high reset
//   chip_sel/en/write/addr, wdata    processor bus access (access = sel && en)
//   rdata                            registered read data, 0 when no read
//   control_reg/data_count/slave_addr  CTRL/COUNT/SADDR to the master
//   status_reg                       master status, bit0 = transfer done
//   tx_data/tx_valid/tx_ready        TX FIFO head towards the master
//   rx_data/rx_valid/rx_ready        received bytes from the master
//   irq                              registered |(ISR & IER)
module i2c_regif_fifo
    import i2c_regif_pkg::*;
#(
    parameter int DW    = 8,
    parameter int BW    = 32,
    parameter int AW    = 8,
    parameter int DEPTH = 8,
    parameter int RX_TH = 1
) (
    input  logic          CLK,
    input  logic          rstn,
    input  logic          chip_sel,
    input  logic          chip_en,
    input  logic          chip_write,
    input  logic [AW-1:0] chip_addr,
    input  logic [BW-1:0] wdata,
    output logic [BW-1:0] rdata,
    output logic [DW-1:0] control_reg,
    output logic [DW-1:0] data_count,
    output logic [DW-1:0] slave_addr,
    input  logic [7:0]    status_reg,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          irq
);

    localparam int LW = $clog2(DEPTH) + 1;

    function automatic logic hit(input logic [AW-1:0] addr, input logic [7:0] reg_addr);
        return addr == AW'(reg_addr);
    endfunction

    logic             wr_acc, rd_acc;
    logic             tx_push, tx_pop, tx_flush, tx_empty, tx_full;
    logic             rx_push, rx_pop, rx_flush, rx_empty, rx_full;
    logic [DW-1:0]    rx_dout;
    logic [LW-1:0]    tx_level, rx_level, rx_level_nxt, unused_tx_lvl_nxt;
    logic [ISR_W-1:0] isr_q, ier_q, isr_set, isr_w1c, isr_nxt, ier_nxt;
    logic             st_done_p1, st_done_p2;
    logic [BW-1:0]    rdata_nxt;
    logic             unused_bits;

    assign wr_acc   = chip_sel && chip_en && chip_write;
    assign rd_acc   = chip_sel && chip_en && !chip_write;
    assign tx_push  = wr_acc && hit(chip_addr, A_TXDATA);
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_flush = wr_acc && hit(chip_addr, A_FCTRL) && wdata[0];
    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = rd_acc && hit(chip_addr, A_RXDATA);
    assign rx_flush = wr_acc && hit(chip_addr, A_FCTRL) && wdata[1];
    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full;

    assign unused_bits = ^{wdata[BW-1:DW], unused_tx_lvl_nxt};

    i2c_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(CLK), .rstn(rstn), .push(tx_push), .din(wdata[DW-1:0]), .pop(tx_pop),
        .flush(tx_flush), .dout(tx_data), .empty(tx_empty), .full(tx_full),
        .level(tx_level), .level_nxt(unused_tx_lvl_nxt)
    );

    i2c_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(CLK), .rstn(rstn), .push(rx_push), .din(rx_data), .pop(rx_pop),
        .flush(rx_flush), .dout(rx_dout), .empty(rx_empty), .full(rx_full),
        .level(rx_level), .level_nxt(rx_level_nxt)
    );

    // Interrupt sources; a W1C write to a bit that is being set this cycle loses.
    always_comb begin
        isr_set               = '0;
        isr_set[ISR_TX_OVF]   = tx_push && tx_full && !tx_pop;
        isr_set[ISR_RX_UNF]   = rx_pop && rx_empty;
        isr_set[ISR_RX_AVAIL] = (rx_level < LW'(RX_TH)) && (rx_level_nxt >= LW'(RX_TH));
        isr_set[ISR_TX_DONE]  = st_done_p1 && !st_done_p2;
        isr_w1c = (wr_acc && hit(chip_addr, A_ISR)) ? wdata[ISR_W-1:0] : '0;
        isr_nxt = (isr_q & ~isr_w1c) | isr_set;
        ier_nxt = (wr_acc && hit(chip_addr, A_IER)) ? wdata[ISR_W-1:0] : ier_q;
    end

    always_comb begin
        rdata_nxt = '0;
        if (rd_acc) begin
            case (chip_addr)
                AW'(A_CTRL):   rdata_nxt = BW'(control_reg);
                AW'(A_COUNT):  rdata_nxt = BW'(data_count);
                AW'(A_SADDR):  rdata_nxt = BW'(slave_addr);
                AW'(A_STATUS): rdata_nxt = BW'({4'b0, rx_full, rx_empty, tx_full, tx_empty, status_reg});
                AW'(A_RXDATA): rdata_nxt = rx_empty ? '0 : BW'(rx_dout);
                AW'(A_IER):    rdata_nxt = BW'(ier_q);
                AW'(A_ISR):    rdata_nxt = BW'(isr_q);
                AW'(A_LEVEL):  rdata_nxt = BW'({16'(rx_level), 16'(tx_level)});
                default:       rdata_nxt = '0;
            endcase
        end
    end

    // Register stage: config registers, interrupt state, read data.
    always_ff @(posedge CLK) begin
        if (rstn) begin
            control_reg <= '0;
            data_count  <= '0;
            slave_addr  <= '0;
            isr_q       <= '0;
            ier_q       <= '0;
            irq         <= 1'b0;
            st_done_p1  <= 1'b0;
            st_done_p2  <= 1'b0;
            rdata       <= '0;
        end else begin
            if (wr_acc && hit(chip_addr, A_CTRL))  control_reg <= wdata[DW-1:0];
            if (wr_acc && hit(chip_addr, A_COUNT)) data_count  <= wdata[DW-1:0];
            if (wr_acc && hit(chip_addr, A_SADDR)) slave_addr  <= wdata[DW-1:0];
            isr_q      <= isr_nxt;
            ier_q      <= ier_nxt;
            irq        <= |(isr_nxt & ier_nxt);
            st_done_p1 <= status_reg[0];
            st_done_p2 <= st_done_p1;
            rdata      <= rdata_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_regif_fifo.sv
module tb_i2c_regif_fifo;

    localparam int RX_TH = 1;
    localparam int DEPTH = 8;

    logic        CLK = 1'b0;
    logic        rstn = 1'b1;
    logic        chip_sel = 1'b0, chip_en = 1'b0, chip_write = 1'b0;
    logic [7:0]  chip_addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  control_reg, data_count, slave_addr;
    logic [7:0]  status_reg = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        irq;

    i2c_regif_fifo #(.DW(8), .BW(32), .AW(8), .DEPTH(DEPTH), .RX_TH(RX_TH)) dut (
        .CLK(CLK), .rstn(rstn), .chip_sel(chip_sel), .chip_en(chip_en),
        .chip_write(chip_write), .chip_addr(chip_addr), .wdata(wdata), .rdata(rdata),
        .control_reg(control_reg), .data_count(data_count), .slave_addr(slave_addr),
        .status_reg(status_reg), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    logic [7:0]  m_ctrl, m_cnt, m_sad;
    logic [3:0]  m_ier, m_isr;
    logic        m_s1, m_s2;
    logic [31:0] last_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        txq.delete(); rxq.delete();
        m_ctrl = '0; m_cnt = '0; m_sad = '0; m_ier = '0; m_isr = '0;
        m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    // One clock cycle: predict from the model, drive, clock, compare.
    task automatic step(input logic acc, input logic wr, input logic [7:0] a, input logic [31:0] d,
                        input logic txr, input logic rxv, input logic [7:0] rxd);
        logic [31:0] erd;
        logic [3:0]  set, w1c;
        int          txn, rxn;
        logic        txp, rxfl, eirq;
        logic        f_txe, f_txf, f_rxe, f_rxf;
        erd = '0; set = '0; w1c = '0; rxfl = 1'b0;
        txn = txq.size(); rxn = rxq.size();
        txp = txr && (txn > 0);
        f_txe = (txn == 0); f_txf = (txn == DEPTH);
        f_rxe = (rxn == 0); f_rxf = (rxn == DEPTH);
        if (acc && !wr) begin
            case (a)
                8'h00: erd = 32'(m_ctrl);
                8'h04: erd = 32'(m_cnt);
                8'h08: erd = 32'(m_sad);
                8'h0C: erd = {20'h0, f_rxf, f_rxe, f_txf, f_txe, status_reg};
                8'h14: if (rxn > 0) erd = 32'(rxq[0]); else set[1] = 1'b1;
                8'h18: erd = 32'(m_ier);
                8'h1C: erd = 32'(m_isr);
                8'h20: erd = (32'(rxn) << 16) | 32'(txn);
                default: erd = '0;
            endcase
            if (a == 8'h14 && rxn > 0) void'(rxq.pop_front());
        end
        if (txp) void'(txq.pop_front());
        if (acc && wr) begin
            case (a)
                8'h00: m_ctrl = d[7:0];
                8'h04: m_cnt  = d[7:0];
                8'h08: m_sad  = d[7:0];
                8'h10: if (txn < DEPTH || txp) txq.push_back(d[7:0]); else set[0] = 1'b1;
                8'h18: m_ier = d[3:0];
                8'h1C: w1c = d[3:0];
                8'h24: begin
                    if (d[0]) txq.delete();
                    rxfl = d[1];
                end
                default: ;
            endcase
        end
        if (rxfl) rxq.delete();
        else if (rxv && rxn < DEPTH) rxq.push_back(rxd);
        if (rxn < RX_TH && rxq.size() >= RX_TH) set[2] = 1'b1;
        if (m_s1 && !m_s2) set[3] = 1'b1;
        m_s2 = m_s1;
        m_s1 = status_reg[0];
        m_isr = (m_isr & ~w1c) | set;
        eirq = |(m_isr & m_ier);

        chip_sel = acc; chip_en = acc; chip_write = wr; chip_addr = a; wdata = d;
        tx_ready = txr; rx_valid = rxv; rx_data = rxd;
        @(posedge CLK); #1;
        last_rd = rdata;
        chk("rdata", rdata, erd);
        chk("irq", 32'(irq), 32'(eirq));
        chk("tx_valid", 32'(tx_valid), 32'(txq.size() > 0));
        if (txq.size() > 0) chk("tx_data", 32'(tx_data), 32'(txq[0]));
        chk("rx_ready", 32'(rx_ready), 32'(rxq.size() < DEPTH));
        chk("ctrl_out", 32'(control_reg), 32'(m_ctrl));
        chk("count_out", 32'(data_count), 32'(m_cnt));
        chk("saddr_out", 32'(slave_addr), 32'(m_sad));
        chip_sel = 1'b0; chip_en = 1'b0; chip_write = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, a, d, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic bus_rd(input logic [7:0] a);
        step(1'b1, 1'b0, a, 32'h0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got[$];
        logic [7:0] ra;
        int         r;

        // Reset held for two cycles
        rstn = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_rx_ready", 32'(rx_ready), 32'h1);
        rstn = 1'b0;
        m_reset();
        bus_rd(8'h20);
        chk("rst_level", last_rd, 32'h0);

        // Config registers
        bus_wr(8'h00, 32'hA5);
        bus_wr(8'h08, 32'h50);
        bus_wr(8'h04, 32'h03);
        bus_rd(8'h00); chk("ctrl_rd", last_rd, 32'hA5);
        bus_rd(8'h08); chk("saddr_rd", last_rd, 32'h50);
        bus_rd(8'h04); chk("count_rd", last_rd, 32'h03);
        step(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00);
        chk("rdata_idle", last_rd, 32'h0);
        bus_wr(8'h30, 32'hFFFF_FFFF);
        bus_rd(8'h30); chk("unmapped_rd", last_rd, 32'h0);
        for (int i = 0; i < 6; i++) begin
            ra = 8'(4 * $urandom_range(0, 2));
            bus_wr(ra, $urandom);
            bus_rd(ra);
        end

        // Overfill TX with the master stalled, then drain
        for (int b = 1; b <= 9; b++) bus_wr(8'h10, 32'(b));
        bus_rd(8'h20); chk("tx_full_level", last_rd, 32'h0000_0008);
        bus_rd(8'h0C); chk("tx_full_status", last_rd, 32'h0000_0600);
        bus_rd(8'h1C); chk("tx_ovf_isr", last_rd, 32'h1);
        for (int k = 0; k < 12; k++) begin
            if (tx_valid) got.push_back(tx_data);
            step(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h00);
        end
        chk("tx_drain_n", 32'(got.size()), 32'd8);
        for (int k = 0; k < got.size(); k++) chk("tx_drain_byte", 32'(got[k]), 32'(k + 1));
        bus_wr(8'h1C, 32'hF);

        // RX availability interrupt
        bus_wr(8'h18, 32'h4);
        step(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 8'h3C);
        chk("rx_avail_irq", 32'(irq), 32'h1);
        bus_rd(8'h14); chk("rx_pop", last_rd, 32'h3C);
        bus_wr(8'h1C, 32'h4);
        chk("irq_cleared", 32'(irq), 32'h0);

        // Underflow, then simultaneous push/pop on both FIFOs
        bus_rd(8'h14); chk("rx_unf_data", last_rd, 32'h0);
        bus_rd(8'h1C); chk("rx_unf_isr", last_rd, 32'h2);
        bus_wr(8'h1C, 32'h2);
        bus_wr(8'h10, 32'h11); bus_wr(8'h10, 32'h22); bus_wr(8'h10, 32'h33);
        step(1'b1, 1'b1, 8'h10, 32'h44, 1'b1, 1'b0, 8'h00);
        chk("tx_head_after_pop", 32'(tx_data), 32'h22);
        step(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 8'h55);
        step(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 8'h66);
        step(1'b1, 1'b0, 8'h14, 32'h0, 1'b0, 1'b1, 8'h77);
        chk("rx_pop_push", last_rd, 32'h55);
        bus_rd(8'h20); chk("levels_kept", last_rd, 32'h0002_0003);

        // Flushes
        bus_wr(8'h10, 32'h88); bus_wr(8'h10, 32'h99);
        bus_rd(8'h20); chk("tx_level5", last_rd, 32'h0002_0005);
        bus_wr(8'h24, 32'h1);
        chk("tx_flush_valid", 32'(tx_valid), 32'h0);
        bus_rd(8'h20); chk("tx_flush_level", last_rd, 32'h0002_0000);
        step(1'b1, 1'b1, 8'h24, 32'h2, 1'b0, 1'b1, 8'hAB);
        bus_rd(8'h20); chk("rx_flush_level", last_rd, 32'h0);

        // Transfer-done edge
        status_reg = 8'h01;
        repeat (3) step(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00);
        bus_rd(8'h1C); chk("tx_done_isr", 32'(last_rd[3]), 32'h1);

        // Reset in the middle of traffic
        bus_wr(8'h10, 32'h5A);
        step(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 8'hC3);
        rstn = 1'b1;
        @(posedge CLK); #1;
        rstn = 1'b0;
        m_reset();
        chk("midrst_tx_valid", 32'(tx_valid), 32'h0);
        chk("midrst_rx_ready", 32'(rx_ready), 32'h1);
        chk("midrst_irq", 32'(irq), 32'h0);
        chk("midrst_rdata", rdata, 32'h0);

        // Randomized traffic against the model
        bus_wr(8'h18, 32'($urandom_range(1, 15)));
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 20);
            if (r <= 5)       step(1'b1, 1'b1, 8'h10, $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 8'($urandom));
            else if (r <= 9)  step(1'b1, 1'b0, 8'h14, 32'h0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 8'($urandom));
            else if (r == 10) step(1'b1, 1'b0, 8'h20, 32'h0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom));
            else if (r == 11) step(1'b1, 1'b0, 8'h0C, 32'h0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom));
            else if (r == 12) step(1'b1, 1'b0, 8'h1C, 32'h0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom));
            else if (r == 13) step(1'b1, 1'b1, 8'h1C, $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom));
            else if (r == 14) step(1'b1, 1'b1, 8'h24, 32'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom));
            else              step(1'b0, 1'b0, 8'h00, 32'h0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
